tl_ul_protocol_checker: RTL and testbench

TL_UL_PROTOCOL_CHECKER -- requirements
Module: tl_ul_protocol_checker

---
 rtl/tl_ul_protocol_checker_if.sv | 33 +++
 rtl/tl_ul_protocol_checker.sv | 213 +++++++++++++++++++++
 tb/tb_tl_ul_protocol_checker.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_protocol_checker_if.sv
// TileLink-UL A/D channel signal bundle observed by the protocol checker.
// The master modport drives the bus; the slave modport only watches it.
interface tl_ul_protocol_checker_if #(
    parameter int SOURCE_W = 2,
    parameter int ADDR_W   = 15,
    parameter int SIZE_W   = 4
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [SIZE_W-1:0]   a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [SIZE_W-1:0]   d_size;
    logic [SOURCE_W-1:0] d_source;

    modport master (
        output a_valid, a_ready, a_opcode, a_param, a_size, a_source,
        output a_address,
        output d_valid, d_ready, d_opcode, d_param, d_size, d_source
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_param, a_size, a_source,
        input a_address,
        input d_valid, d_ready, d_opcode, d_param, d_size, d_source
    );
endinterface

// File: rtl/tl_ul_protocol_checker.sv
// TileLink-UL passive protocol checker: encoding, stability, per-source
// request tracking and timeout, reported as pulse/sticky/first-error.
module tl_ul_protocol_checker #(
    parameter int SOURCE_W = 2,
    parameter int ADDR_W   = 15,
    parameter int SIZE_W   = 4,
    parameter int MAX_SIZE = 3,
    parameter int TIMEOUT  = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tl_ul_protocol_checker_if.slave bus,
    input  logic                   enable,
    input  logic                   err_clear,
    output logic                   err_pulse,
    output logic [8:0]             err_sticky,
    output logic [3:0]             first_err,
    output logic                   first_err_valid,
    output logic [SOURCE_W:0]      inflight_count
);
    localparam int N  = 1 << SOURCE_W;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SIZE_W-1:0] S_MAX = SIZE_W'(MAX_SIZE);

    logic                a_fire;
    logic                d_fire;
    logic [8:0]          err;
    logic [8:0]          new_err;
    logic [3:0]          err_low;
    logic [ADDR_W-1:0]   amask;
    logic [SOURCE_W:0]   count_d;

    logic [N-1:0]        infl_q, infl_d;
    logic [N-1:0]        get_q, get_d;
    logic [N-1:0]        tdone_q, tdone_d;
    logic [SIZE_W-1:0]   size_q [N];
    logic [SIZE_W-1:0]   size_d [N];
    logic [TW-1:0]       tmr_q [N];
    logic [TW-1:0]       tmr_d [N];

    logic                a_hold_q;
    logic [2:0]          a_op_q;
    logic [2:0]          a_param_q;
    logic [SIZE_W-1:0]   a_size_q;
    logic [SOURCE_W-1:0] a_src_q;
    logic [ADDR_W-1:0]   a_addr_q;
    logic                d_hold_q;
    logic [2:0]          d_op_q;
    logic [1:0]          d_param_q;
    logic [SIZE_W-1:0]   d_size_q;
    logic [SOURCE_W-1:0] d_src_q;

    assign a_fire  = bus.a_valid & bus.a_ready;
    assign d_fire  = bus.d_valid & bus.d_ready;
    assign new_err = (enable & ~err_clear) ? err : 9'd0;

    // Low-order address bits that must be zero for the requested size.
    always_comb begin
        amask = '0;
        for (int i = 0; i < ADDR_W; i++)
            amask[i] = ($unsigned(i) < 32'(bus.a_size));
    end

    // Detect all error conditions and compute next tracking state.
    always_comb begin
        err     = '0;
        infl_d  = infl_q;
        get_d   = get_q;
        tdone_d = tdone_q;
        size_d  = size_q;
        tmr_d   = tmr_q;

        if (bus.a_valid) begin
            err[0] = !((bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1) ||
                       (bus.a_opcode == 3'd4));
            err[1] = (bus.a_param != 3'd0);
            err[2] = (bus.a_size > S_MAX) || |(bus.a_address & amask);
        end

        err[3] = a_hold_q & (!bus.a_valid ||
                             (bus.a_opcode != a_op_q) ||
                             (bus.a_param != a_param_q) ||
                             (bus.a_size != a_size_q) ||
                             (bus.a_source != a_src_q) ||
                             (bus.a_address != a_addr_q));
        err[7] = d_hold_q & (!bus.d_valid ||
                             (bus.d_opcode != d_op_q) ||
                             (bus.d_param != d_param_q) ||
                             (bus.d_size != d_size_q) ||
                             (bus.d_source != d_src_q));

        for (int i = 0; i < N; i++)
            if (infl_q[i] && (tmr_q[i] != '1))
                tmr_d[i] = tmr_q[i] + 1'b1;

        // D is judged against the entry as it stood before this cycle;
        // a response to an idle source is a bit-5 error only.
        if (d_fire) begin
            err[5] = !infl_q[bus.d_source];
            err[6] = infl_q[bus.d_source] &
                     ((bus.d_opcode != {2'b00, get_q[bus.d_source]}) ||
                      (bus.d_size != size_q[bus.d_source]) ||
                      (bus.d_param != 2'd0));
            infl_d[bus.d_source] = 1'b0;
        end

        // A new request always overwrites, so a same-cycle D on the same
        // source leaves the entry in flight with the new values.
        if (a_fire) begin
            err[4]                = infl_q[bus.a_source];
            infl_d[bus.a_source]  = 1'b1;
            get_d[bus.a_source]   = (bus.a_opcode == 3'd4);
            size_d[bus.a_source]  = bus.a_size;
            tmr_d[bus.a_source]   = '0;
            tdone_d[bus.a_source] = 1'b0;
        end

        if (TIMEOUT != 0) begin
            for (int i = 0; i < N; i++) begin
                if (infl_d[i] && !tdone_d[i] && (tmr_d[i] == T_LAST)) begin
                    err[8]     = 1'b1;
                    tdone_d[i] = 1'b1;
                end
            end
        end
    end

    // Lowest set error index and popcount of next inflight bits.
    always_comb begin
        err_low = '0;
        for (int i = 8; i >= 0; i--)
            if (new_err[i]) err_low = 4'(i);
        count_d = '0;
        for (int i = 0; i < N; i++)
            count_d = count_d + (SOURCE_W+1)'(infl_d[i]);
    end

    // Per-source tracking table.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            infl_q  <= '0;
            get_q   <= '0;
            tdone_q <= '0;
            for (int i = 0; i < N; i++) begin
                size_q[i] <= '0;
                tmr_q[i]  <= '0;
            end
        end else begin
            infl_q  <= infl_d;
            get_q   <= get_d;
            tdone_q <= tdone_d;
            for (int i = 0; i < N; i++) begin
                size_q[i] <= size_d[i];
                tmr_q[i]  <= tmr_d[i];
            end
        end
    end

    // Channel stall history for the stability checks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_hold_q  <= 1'b0;
            a_op_q    <= '0;
            a_param_q <= '0;
            a_size_q  <= '0;
            a_src_q   <= '0;
            a_addr_q  <= '0;
            d_hold_q  <= 1'b0;
            d_op_q    <= '0;
            d_param_q <= '0;
            d_size_q  <= '0;
            d_src_q   <= '0;
        end else begin
            a_hold_q  <= bus.a_valid & ~bus.a_ready;
            a_op_q    <= bus.a_opcode;
            a_param_q <= bus.a_param;
            a_size_q  <= bus.a_size;
            a_src_q   <= bus.a_source;
            a_addr_q  <= bus.a_address;
            d_hold_q  <= bus.d_valid & ~bus.d_ready;
            d_op_q    <= bus.d_opcode;
            d_param_q <= bus.d_param;
            d_size_q  <= bus.d_size;
            d_src_q   <= bus.d_source;
        end
    end

    // Error reporting; err_clear wins over same-cycle errors.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse       <= 1'b0;
            err_sticky      <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            inflight_count  <= '0;
        end else begin
            err_pulse      <= |new_err;
            inflight_count <= count_d;
            if (err_clear) begin
                err_sticky      <= '0;
                first_err       <= '0;
                first_err_valid <= 1'b0;
            end else begin
                err_sticky <= err_sticky | new_err;
                if (!first_err_valid && |new_err) begin
                    first_err       <= err_low;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tl_ul_protocol_checker.sv
// Bench for tl_ul_protocol_checker: vector table, directed corner
// sequences and random traffic against a request-level reference model.
module tb_tl_ul_protocol_checker;
    localparam int SW = 2;
    localparam int AW = 15;
    localparam int ZW = 4;
    localparam int MS = 3;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          err_clear = 1'b0;
    logic          err_pulse;
    logic [8:0]    err_sticky;
    logic [3:0]    first_err;
    logic          first_err_valid;
    logic [SW:0]   inflight_count;

    tl_ul_protocol_checker_if #(.SOURCE_W(SW), .ADDR_W(AW), .SIZE_W(ZW)) bus ();

    tl_ul_protocol_checker #(
        .SOURCE_W(SW), .ADDR_W(AW), .SIZE_W(ZW),
        .MAX_SIZE(MS), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .enable(enable),
        .err_clear(err_clear),
        .err_pulse(err_pulse),
        .err_sticky(err_sticky),
        .first_err(first_err),
        .first_err_valid(first_err_valid),
        .inflight_count(inflight_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (request level) ----------------
    typedef struct {
        bit out;
        bit get;
        int size;
        int age;
    } ent_t;

    ent_t tab[4];
    bit   ma_st, md_st;
    int   ma_op, ma_pa, ma_sz, ma_src, ma_ad;
    int   md_op, md_pa, md_sz, md_src;
    bit   m_pulse, m_fv;
    int   m_sticky, m_first, m_count;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) tab[i] = '{0, 0, 0, 0};
        ma_st = 0; md_st = 0;
        m_pulse = 0; m_fv = 0; m_sticky = 0; m_first = 0; m_count = 0;
    endtask

    task automatic model_edge();
        int e;
        bit af, df;
        int op, pa, sz, as, ad, dop, dpa, dsz, ds;
        e = 0;
        af = bus.a_valid && bus.a_ready;
        df = bus.d_valid && bus.d_ready;
        op = int'(bus.a_opcode); pa = int'(bus.a_param);
        sz = int'(bus.a_size); as = int'(bus.a_source);
        ad = int'(bus.a_address);
        dop = int'(bus.d_opcode); dpa = int'(bus.d_param);
        dsz = int'(bus.d_size); ds = int'(bus.d_source);
        if (bus.a_valid) begin
            if (!(op == 0 || op == 1 || op == 4)) e |= 1;
            if (pa != 0) e |= 2;
            if (sz > MS || (ad % (1 << sz)) != 0) e |= 4;
        end
        if (ma_st && (!bus.a_valid || op != ma_op || pa != ma_pa ||
                      sz != ma_sz || as != ma_src || ad != ma_ad)) e |= 8;
        if (md_st && (!bus.d_valid || dop != md_op || dpa != md_pa ||
                      dsz != md_sz || ds != md_src)) e |= 128;
        if (df) begin
            if (!tab[ds].out) e |= 32;
            else if (dop != (tab[ds].get ? 1 : 0) || dsz != tab[ds].size ||
                     dpa != 0) e |= 64;
        end
        if (af && tab[as].out) e |= 16;
        for (int i = 0; i < 4; i++) if (tab[i].out) tab[i].age++;
        if (df) tab[ds].out = 0;
        if (af) tab[as] = '{1, (op == 4), sz, 0};
        for (int i = 0; i < 4; i++)
            if (tab[i].out && tab[i].age == TO - 1) e |= 256;
        ma_st = bus.a_valid && !bus.a_ready;
        ma_op = op; ma_pa = pa; ma_sz = sz; ma_src = as; ma_ad = ad;
        md_st = bus.d_valid && !bus.d_ready;
        md_op = dop; md_pa = dpa; md_sz = dsz; md_src = ds;
        if (!enable || err_clear) e = 0;
        m_pulse = (e != 0);
        if (err_clear) begin
            m_sticky = 0; m_fv = 0; m_first = 0;
        end else begin
            m_sticky |= e;
            if (!m_fv && e != 0) begin
                for (int b = 8; b >= 0; b--) if (e[b]) m_first = b;
                m_fv = 1;
            end
        end
        m_count = 0;
        for (int i = 0; i < 4; i++) if (tab[i].out) m_count++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".sticky"}, 32'(err_sticky), m_sticky);
        chk({tag, ".first"}, 32'(first_err), m_first);
        chk({tag, ".first_v"}, 32'(first_err_valid), 32'(m_fv));
        chk({tag, ".count"}, 32'(inflight_count), m_count);
    endtask

    // ---------------- drive helpers ----------------
    task automatic set_a(input logic v, input logic r, input logic [2:0] op,
                         input logic [2:0] pa, input logic [3:0] sz,
                         input logic [1:0] src, input logic [14:0] ad);
        bus.a_valid = v; bus.a_ready = r; bus.a_opcode = op;
        bus.a_param = pa; bus.a_size = sz; bus.a_source = src;
        bus.a_address = ad;
    endtask

    task automatic set_d(input logic v, input logic r, input logic [2:0] op,
                         input logic [1:0] pa, input logic [3:0] sz,
                         input logic [1:0] src);
        bus.d_valid = v; bus.d_ready = r; bus.d_opcode = op;
        bus.d_param = pa; bus.d_size = sz; bus.d_source = src;
    endtask

    task automatic idle();
        bus.a_valid = 0; bus.a_ready = 1;
        bus.d_valid = 0; bus.d_ready = 1;
        err_clear = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_errs();
        idle();
        err_clear = 1;
        step();
        err_clear = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  pa;
        logic [3:0]  sz;
        logic [1:0]  src;
        logic [14:0] ad;
        logic [8:0]  exp;
        logic [3:0]  first;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{3'd4, 3'd0, 4'd2, 2'd1, 15'h0004, 9'h000, 4'd0};
        vt[1] = '{3'd0, 3'd0, 4'd2, 2'd0, 15'h0003, 9'h004, 4'd2};
        vt[2] = '{3'd2, 3'd0, 4'd2, 2'd2, 15'h0010, 9'h001, 4'd0};
        vt[3] = '{3'd7, 3'd1, 4'd2, 2'd3, 15'h0020, 9'h003, 4'd0};
        vt[4] = '{3'd1, 3'd0, 4'd3, 2'd0, 15'h0008, 9'h000, 4'd0};
        vt[5] = '{3'd4, 3'd0, 4'd4, 2'd1, 15'h0000, 9'h004, 4'd2};
        vt[6] = '{3'd4, 3'd0, 4'd0, 2'd2, 15'h7FFF, 9'h000, 4'd0};
        vt[7] = '{3'd0, 3'd0, 4'd1, 2'd3, 15'h0001, 9'h004, 4'd2};
        vt[8] = '{3'd4, 3'd3, 4'd3, 2'd0, 15'h0010, 9'h002, 4'd1};
        vt[9] = '{3'd3, 3'd2, 4'd5, 2'd1, 15'h0001, 9'h007, 4'd0};

        set_a(0, 1, 0, 0, 0, 0, 0);
        set_d(0, 1, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst.pulse", 32'(err_pulse), 0);
        chk("rst.sticky", 32'(err_sticky), 0);
        chk("rst.first", 32'(first_err), 0);
        chk("rst.first_v", 32'(first_err_valid), 0);
        chk("rst.count", 32'(inflight_count), 0);
        reset_n = 1;

        for (int i = 0; i < 10; i++) begin
            clear_errs();
            set_a(1, 1, vt[i].op, vt[i].pa, vt[i].sz, vt[i].src, vt[i].ad);
            step();
            chk("vec.pulse", 32'(err_pulse), 32'(vt[i].exp != 0));
            chk("vec.sticky", 32'(err_sticky), 32'(vt[i].exp));
            chk("vec.first", 32'(first_err), 32'(vt[i].first));
            chk("vec.count1", 32'(inflight_count), 1);
            idle();
            set_d(1, 1, (vt[i].op == 3'd4) ? 3'd1 : 3'd0, 0, vt[i].sz,
                  vt[i].src);
            step();
            chk("vec.d_pulse", 32'(err_pulse), 0);
            chk("vec.count0", 32'(inflight_count), 0);
            check_model("vec");
        end

        // A channel changes while stalled
        clear_errs();
        set_a(1, 0, 4, 0, 2, 0, 15'h0004);
        step();
        chk("astab.quiet", 32'(err_pulse), 0);
        set_a(1, 0, 4, 0, 2, 0, 15'h0008);
        step();
        chk("astab.pulse", 32'(err_pulse), 1);
        chk("astab.sticky", 32'(err_sticky), 32'h008);
        chk("astab.first", 32'(first_err), 3);
        set_a(1, 1, 4, 0, 2, 0, 15'h0008);
        step();
        chk("astab.fire", 32'(err_pulse), 0);
        idle();
        set_d(1, 1, 1, 0, 2, 0);
        step();
        chk("astab.count", 32'(inflight_count), 0);

        // D valid dropped before ready
        clear_errs();
        set_a(1, 1, 4, 0, 2, 1, 15'h0004);
        step();
        idle();
        set_d(1, 0, 1, 0, 2, 1);
        step();
        chk("dstab.quiet", 32'(err_pulse), 0);
        bus.d_valid = 0;
        step();
        chk("dstab.pulse", 32'(err_pulse), 1);
        chk("dstab.sticky", 32'(err_sticky), 32'h080);
        set_d(1, 1, 1, 0, 2, 1);
        step();
        chk("dstab.count", 32'(inflight_count), 0);

        // Source busy
        clear_errs();
        set_a(1, 1, 4, 0, 2, 2, 15'h0004);
        step();
        step();
        chk("busy.sticky", 32'(err_sticky), 32'h010);
        chk("busy.first", 32'(first_err), 4);
        chk("busy.count", 32'(inflight_count), 1);
        idle();
        set_d(1, 1, 1, 0, 2, 2);
        step();
        chk("busy.d_pulse", 32'(err_pulse), 0);

        // Response to a source never requested
        clear_errs();
        set_d(1, 1, 0, 0, 2, 3);
        step();
        chk("nosrc.sticky", 32'(err_sticky), 32'h020);

        // PutFull answered with AccessAckData
        clear_errs();
        set_a(1, 1, 0, 0, 2, 0, 15'h0004);
        step();
        idle();
        set_d(1, 1, 1, 0, 2, 0);
        step();
        chk("mism.sticky", 32'(err_sticky), 32'h040);
        chk("mism.count", 32'(inflight_count), 0);

        // err_clear in the same cycle as a new error
        clear_errs();
        set_a(1, 1, 2, 0, 2, 0, 15'h0004);
        err_clear = 1;
        step();
        err_clear = 0;
        chk("clr.sticky", 32'(err_sticky), 0);
        chk("clr.pulse", 32'(err_pulse), 0);
        chk("clr.first_v", 32'(first_err_valid), 0);
        chk("clr.count", 32'(inflight_count), 1);
        idle();
        set_d(1, 1, 0, 0, 2, 0);
        step();
        chk("clr.after", 32'(err_sticky), 0);

        // Reporting disabled, tracking continues
        enable = 0;
        set_a(1, 1, 7, 0, 2, 1, 15'h0001);
        step();
        chk("dis.pulse", 32'(err_pulse), 0);
        chk("dis.count", 32'(inflight_count), 1);
        idle();
        set_d(1, 1, 1, 0, 2, 1);
        step();
        chk("dis.sticky", 32'(err_sticky), 0);
        chk("dis.count0", 32'(inflight_count), 0);
        enable = 1;

        // Timeout fires once, TO-1 edges after the request
        clear_errs();
        set_a(1, 1, 4, 0, 2, 0, 15'h0004);
        step();
        idle();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("tmo.pulse%0d", k), 32'(err_pulse), 32'(k == 7));
        end
        chk("tmo.sticky", 32'(err_sticky), 32'h100);
        chk("tmo.first", 32'(first_err), 8);
        chk("tmo.count", 32'(inflight_count), 1);
        set_d(1, 1, 1, 0, 2, 0);
        step();
        chk("tmo.late_d", 32'(err_pulse), 0);
        check_model("tmo");

        // Reset with three requests outstanding and A stalled
        clear_errs();
        for (int s = 0; s < 3; s++) begin
            set_a(1, 1, 4, 0, 2, 2'(s), 15'h0004);
            step();
        end
        chk("rst3.count", 32'(inflight_count), 3);
        set_a(1, 0, 4, 0, 2, 3, 15'h0004);
        step();
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("rst3.async", 32'(inflight_count), 0);
        @(posedge clock);
        #1;
        reset_n = 1;
        idle();
        set_d(1, 1, 1, 0, 2, 1);
        step();
        chk("rst3.d_sticky", 32'(err_sticky), 32'h020);
        chk("rst3.d_pulse", 32'(err_pulse), 1);

        // Random traffic against the model
        clear_errs();
        for (int c = 0; c < 3000; c++) begin
            int sz, src, r;
            logic [14:0] ad;
            if (!(ma_st && ($urandom % 10 != 0))) begin
                r = $urandom % 3;
                sz = ($urandom % 8 == 0) ? $urandom_range(15, 0)
                                         : $urandom_range(3, 0);
                ad = 15'($urandom);
                if ($urandom % 8 != 0) ad = ad & ~15'((1 << sz) - 1);
                bus.a_valid = ($urandom % 2 == 0);
                bus.a_opcode = ($urandom % 10 == 0) ? 3'($urandom)
                             : ((r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4);
                bus.a_param = ($urandom % 16 == 0) ? 3'($urandom) : 3'd0;
                bus.a_size = 4'(sz);
                bus.a_source = 2'($urandom);
                bus.a_address = ad;
            end
            bus.a_ready = ($urandom % 4 != 0);
            if (!(md_st && ($urandom % 10 != 0))) begin
                src = $urandom_range(3, 0);
                bus.d_valid = ($urandom % 3 == 0);
                bus.d_source = 2'(src);
                bus.d_opcode = ($urandom % 12 == 0) ? 3'($urandom)
                             : (tab[src].get ? 3'd1 : 3'd0);
                bus.d_size = ($urandom % 12 == 0) ? 4'($urandom)
                           : 4'(tab[src].size);
                bus.d_param = ($urandom % 16 == 0) ? 2'($urandom) : 2'd0;
            end
            bus.d_ready = ($urandom % 3 != 0);
            enable = ($urandom % 20 != 0);
            err_clear = ($urandom % 25 == 0);
            step();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
